// File: rtl/motor_duty_ramp_if.sv
// Speed-command handshake into the duty ramp: signed 15-bit speed with valid/ready.
interface motor_duty_ramp_if;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [14:0] cmd_speed;

  modport master (output cmd_valid, output cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/motor_duty_ramp.sv
// Slew-limited duty generator for the 14-bit PWM stage: ramps vq toward |speed|
// once per PWM period, with reversal dead time, emergency stop and command watchdog.
module motor_duty_ramp #(
  parameter int STEP       = 64,
  parameter int DEAD_TICKS = 4,
  parameter int WDT_TICKS  = 1024,
  // period counter width; 14 keeps lockstep with the PWM counter
  parameter int CNT_W      = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  motor_duty_ramp_if.slave    cmd,
  input  logic                estop,
  output logic [13:0]         vq,
  output logic                dir,
  output logic                at_target,
  output logic                wdt_trip
);

  typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               accept;
  logic [14:0]        spd_abs;
  logic [13:0]        cmd_mag;
  logic [13:0]        mag, mag_nxt;
  logic [13:0]        tgt_mag, tgt_mag_nxt;
  logic               tgt_dir, tgt_dir_nxt;
  logic               dir_nxt;
  logic [7:0]         dcnt, dcnt_nxt;
  logic [15:0]        wcnt, wcnt_nxt;
  logic               wdt_trip_nxt;
  logic               wdt_fire;
  logic               at_target_nxt;

  // 15-bit intermediates keep the sums from wrapping before the clamp
  function automatic logic [13:0] ramp_up(input logic [13:0] cur, input logic [13:0] lim);
    logic [14:0] sum;
    sum = {1'b0, cur} + 15'(STEP);
    return (sum > {1'b0, lim}) ? lim : sum[13:0];
  endfunction

  function automatic logic [13:0] ramp_down(input logic [13:0] cur, input logic [13:0] floor_mag);
    logic [14:0] lo;
    lo = {1'b0, floor_mag} + 15'(STEP);
    return ({1'b0, cur} <= lo) ? floor_mag : cur - 14'(STEP);
  endfunction

  function automatic logic [13:0] approach(input logic [13:0] cur, input logic [13:0] tgt);
    if (cur < tgt)      return ramp_up(cur, tgt);
    else if (cur > tgt) return ramp_down(cur, tgt);
    else                return cur;
  endfunction

  assign cmd.cmd_ready = !estop;
  assign accept        = cmd.cmd_valid && !estop;
  assign tick          = &cnt;
  assign spd_abs       = cmd.cmd_speed[14] ? (15'd0 - cmd.cmd_speed) : cmd.cmd_speed;
  assign cmd_mag       = spd_abs[14] ? 14'h3fff : spd_abs[13:0];
  assign vq            = mag;

  // Target and watchdog; an accept in the tick cycle is seen by that same tick
  always_comb begin
    tgt_mag_nxt  = tgt_mag;
    tgt_dir_nxt  = tgt_dir;
    wcnt_nxt     = wcnt;
    wdt_trip_nxt = wdt_trip;
    wdt_fire     = (WDT_TICKS != 0) && tick && !accept && (wcnt == 16'(WDT_TICKS - 1));
    if (tick && wcnt != 16'hffff) wcnt_nxt = wcnt + 16'd1;
    if (accept) begin
      wcnt_nxt     = '0;
      wdt_trip_nxt = 1'b0;
      tgt_mag_nxt  = cmd_mag;
      if (cmd_mag != '0) tgt_dir_nxt = cmd.cmd_speed[14];
    end else if (wdt_fire) begin
      tgt_mag_nxt  = '0;
      wdt_trip_nxt = 1'b1;
    end
    if (estop) tgt_mag_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    mag_nxt   = mag;
    dir_nxt   = dir;
    dcnt_nxt  = dcnt;
    if (estop) begin
      state_nxt = DEAD;
      mag_nxt   = '0;
      dcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (tgt_mag_nxt != '0) begin
            dir_nxt   = tgt_dir_nxt;
            mag_nxt   = ramp_up(14'd0, tgt_mag_nxt);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (tgt_mag_nxt != '0 && tgt_dir_nxt != dir) begin
            mag_nxt   = ramp_down(mag, 14'd0);
            state_nxt = DECEL;
          end else begin
            mag_nxt   = approach(mag, tgt_mag_nxt);
          end
          if (mag_nxt == '0) begin
            state_nxt = DEAD;
            dcnt_nxt  = '0;
          end
        end
        DECEL: begin
          if (tgt_dir_nxt == dir) begin
            mag_nxt   = approach(mag, tgt_mag_nxt);
            state_nxt = RUN;
          end else begin
            mag_nxt   = ramp_down(mag, 14'd0);
          end
          if (mag_nxt == '0) begin
            state_nxt = DEAD;
            dcnt_nxt  = '0;
          end
        end
        default: begin
          if (dcnt == 8'(DEAD_TICKS)) state_nxt = IDLE;
          else                        dcnt_nxt  = dcnt + 8'd1;
        end
      endcase
    end
    at_target_nxt = (mag_nxt == tgt_mag_nxt) &&
                    (tgt_mag_nxt == '0 || dir_nxt == tgt_dir_nxt) &&
                    (state_nxt == IDLE || state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt       <= '0;
      state     <= IDLE;
      mag       <= '0;
      dir       <= 1'b0;
      tgt_mag   <= '0;
      tgt_dir   <= 1'b0;
      wcnt      <= '0;
      dcnt      <= '0;
      wdt_trip  <= 1'b0;
      at_target <= 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
      state     <= state_nxt;
      mag       <= mag_nxt;
      dir       <= dir_nxt;
      tgt_mag   <= tgt_mag_nxt;
      tgt_dir   <= tgt_dir_nxt;
      wcnt      <= wcnt_nxt;
      dcnt      <= dcnt_nxt;
      wdt_trip  <= wdt_trip_nxt;
      at_target <= at_target_nxt;
    end
  end

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Scoreboard bench for motor_duty_ramp: a per-cycle behavioural model queues the
// expected outputs, a negedge monitor pops and compares; short period for run time.
module tb_motor_duty_ramp;
  localparam int STEP  = 64;
  localparam int DEAD  = 4;
  localparam int WDT   = 8;
  localparam int CNT_W = 4;
  localparam int P     = 1 << CNT_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DECEL = 2;
  localparam int PH_DEAD  = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        estop;
  logic [13:0] vq;
  logic        dir, at_target, wdt_trip;

  motor_duty_ramp_if bus ();

  motor_duty_ramp #(.STEP(STEP), .DEAD_TICKS(DEAD), .WDT_TICKS(WDT), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .cmd(bus), .estop(estop),
    .vq(vq), .dir(dir), .at_target(at_target), .wdt_trip(wdt_trip)
  );

  always #5 clk = ~clk;

  typedef struct {int vq; int dir; int at; int trip; int rdy;} exp_t;
  typedef struct {string name; int got; int want;} dchk_t;

  exp_t  exp_q[$];
  dchk_t dq[$];
  int    errors = 0;
  int    checks = 0;

  // behavioural reference state
  int m_pos, m_mag, m_dir, m_tmag, m_tdir, m_wcnt, m_dcnt, m_trip, m_ph;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return imin(cur + STEP, tgt);
    return imax(cur - STEP, tgt);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mag = 0; m_dir = 0; m_tmag = 0; m_tdir = 0;
    m_wcnt = 0; m_dcnt = 0; m_trip = 0; m_ph = PH_IDLE;
  endtask

  task automatic model_update(input logic v, input logic signed [14:0] s, input logic e);
    int  sv, a;
    bit  tick, acc;
    if (!n_rst) begin
      model_reset();
      return;
    end
    tick = (m_pos == P - 1);
    acc  = v && !e;
    sv   = int'(s);
    a    = (sv < 0) ? -sv : sv;
    if (a > 16383) a = 16383;
    if (acc) begin
      m_tmag = a;
      if (a != 0) m_tdir = (sv < 0) ? 1 : 0;
      m_wcnt = 0;
      m_trip = 0;
    end else if (tick) begin
      if (WDT > 0 && m_wcnt + 1 == WDT) begin
        m_tmag = 0;
        m_trip = 1;
      end
      if (m_wcnt < 65535) m_wcnt++;
    end
    if (e) m_tmag = 0;

    if (e) begin
      m_mag = 0; m_ph = PH_DEAD; m_dcnt = 0;
    end else if (tick) begin
      if (m_ph == PH_IDLE) begin
        if (m_tmag > 0) begin
          m_dir = m_tdir; m_mag = imin(STEP, m_tmag); m_ph = PH_RUN;
        end
      end else if (m_ph == PH_DEAD) begin
        if (m_dcnt == DEAD) m_ph = PH_IDLE;
        else m_dcnt++;
      end else begin
        if (m_ph == PH_RUN && m_tmag > 0 && m_tdir != m_dir) begin
          m_mag = imax(m_mag - STEP, 0); m_ph = PH_DECEL;
        end else if (m_ph == PH_DECEL && m_tdir != m_dir) begin
          m_mag = imax(m_mag - STEP, 0);
        end else begin
          m_mag = toward(m_mag, m_tmag); m_ph = PH_RUN;
        end
        if (m_mag == 0) begin
          m_ph = PH_DEAD; m_dcnt = 0;
        end
      end
    end
    m_pos = (m_pos + 1) % P;
  endtask

  task automatic step(input logic v, input int spd, input logic e);
    exp_t x;
    bus.cmd_valid = v;
    bus.cmd_speed = 15'(spd);
    estop         = e;
    x.vq   = m_mag;
    x.dir  = m_dir;
    x.at   = ((m_mag == m_tmag) && (m_tmag == 0 || m_dir == m_tdir) &&
              (m_ph == PH_IDLE || m_ph == PH_RUN)) ? 1 : 0;
    x.trip = m_trip;
    x.rdy  = e ? 0 : 1;
    exp_q.push_back(x);
    model_update(v, 15'(spd), e);
    @(posedge clk);
    #1;
  endtask

  task automatic periods(input int n, input logic keep, input int spd);
    for (int p = 0; p < n; p++) begin
      int k;
      k = $urandom_range(0, P - 1);
      for (int c = 0; c < P; c++) step(keep && (c == k), spd, 1'b0);
    end
  endtask

  task automatic align();
    while (m_pos != 0) step(1'b0, 0, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    dchk_t d;
    d.name = name; d.got = got; d.want = want;
    dq.push_back(d);
  endtask

  // Monitor: compares the queued expectations against the DUT on the falling edge
  initial begin
    exp_t  x;
    dchk_t d;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if ({vq, dir, at_target, wdt_trip, bus.cmd_ready} !==
            {14'(x.vq), x.dir[0], x.at[0], x.trip[0], x.rdy[0]}) begin
          errors++;
          $display("FAIL scoreboard t=%0t: vq=%0d dir=%0b at=%0b trip=%0b rdy=%0b, expected vq=%0d dir=%0d at=%0d trip=%0d rdy=%0d",
                   $time, vq, dir, at_target, wdt_trip, bus.cmd_ready, x.vq, x.dir, x.at, x.trip, x.rdy);
        end
      end
      while (dq.size() > 0) begin
        d = dq.pop_front();
        checks++;
        if (d.got != d.want) begin
          errors++;
          $display("FAIL %s: got %0d, expected %0d", d.name, d.got, d.want);
        end
      end
    end
  end

  initial begin
    bit eon;
    bus.cmd_valid = 1'b0;
    bus.cmd_speed = '0;
    estop = 1'b0;
    n_rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 0, 1'b0);
    chk("reset_vq", int'(vq), 0);
    chk("reset_at_target", int'(at_target), 1);
    chk("reset_cmd_ready", int'(bus.cmd_ready), 1);
    n_rst = 1'b1;

    // Ramp up to +1000
    align();
    step(1'b1, 1000, 1'b0);
    periods(15, 1'b1, 1000);
    chk("ramp_vq_t15", int'(vq), 960);
    chk("ramp_at_t15", int'(at_target), 0);
    periods(1, 1'b1, 1000);
    chk("ramp_vq_t16", int'(vq), 1000);
    chk("ramp_at_t16", int'(at_target), 1);
    chk("ramp_dir", int'(dir), 0);

    // Reversal from +256 to -128
    periods(14, 1'b1, 256);
    chk("rev_start_vq", int'(vq), 256);
    align();
    step(1'b1, -128, 1'b0);
    periods(1, 1'b1, -128);
    chk("rev_vq_t1", int'(vq), 192);
    periods(3, 1'b1, -128);
    chk("rev_vq_t4", int'(vq), 0);
    chk("rev_dir_t4", int'(dir), 0);
    periods(5, 1'b1, -128);
    chk("rev_vq_t9", int'(vq), 0);
    periods(1, 1'b1, -128);
    chk("rev_vq_t10", int'(vq), 64);
    chk("rev_dir_t10", int'(dir), 1);
    periods(1, 1'b1, -128);
    chk("rev_vq_t11", int'(vq), 128);
    chk("rev_at_t11", int'(at_target), 1);

    // Emergency stop mid-ramp
    periods(6, 1'b1, -1000);
    chk("estop_pre_vq", int'(vq), 512);
    repeat (5) step(1'b0, 0, 1'b0);
    step(1'b1, -1000, 1'b1);
    chk("estop_cmd_ready", int'(bus.cmd_ready), 0);
    chk("estop_vq", int'(vq), 0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    periods(7, 1'b0, 0);
    chk("estop_after_vq", int'(vq), 0);
    chk("estop_after_dir", int'(dir), 1);
    chk("estop_after_at", int'(at_target), 1);

    // Watchdog expiry after +640
    align();
    step(1'b1, 640, 1'b0);
    chk("wdt_clear_on_accept", int'(wdt_trip), 0);
    periods(7, 1'b0, 0);
    chk("wdt_t7_trip", int'(wdt_trip), 0);
    chk("wdt_t7_vq", int'(vq), 448);
    periods(1, 1'b0, 0);
    chk("wdt_t8_trip", int'(wdt_trip), 1);
    chk("wdt_t8_vq", int'(vq), 384);
    periods(8, 1'b0, 0);
    chk("wdt_down_vq", int'(vq), 0);
    step(1'b1, 64, 1'b0);
    chk("wdt_cleared", int'(wdt_trip), 0);
    periods(6, 1'b1, 64);
    chk("wdt_resume_vq", int'(vq), 64);
    chk("wdt_resume_dir", int'(dir), 0);

    // Back-to-back commands in one period: only the last applies
    align();
    step(1'b1, 100, 1'b0);
    step(1'b1, 300, 1'b0);
    step(1'b1, -50, 1'b0);
    repeat (P - 3) step(1'b0, 0, 1'b0);
    chk("b2b_vq_t1", int'(vq), 0);
    periods(6, 1'b1, -50);
    chk("b2b_vq", int'(vq), 50);
    chk("b2b_dir", int'(dir), 1);
    chk("b2b_at", int'(at_target), 1);

    // Zero command, then clamp at -16384
    periods(8, 1'b1, 0);
    chk("zero_vq", int'(vq), 0);
    align();
    step(1'b1, -16384, 1'b0);
    periods(255, 1'b1, -16384);
    chk("clamp_vq_t255", int'(vq), 16320);
    periods(1, 1'b1, -16384);
    chk("clamp_vq_t256", int'(vq), 16383);
    chk("clamp_dir", int'(dir), 1);
    chk("clamp_at", int'(at_target), 1);
    periods(2, 1'b1, -16384);
    chk("clamp_hold_vq", int'(vq), 16383);

    // Randomised commands and emergency stops
    eon = 1'b0;
    for (int i = 0; i < 150 * P; i++) begin
      int r, spd;
      r = $urandom_range(0, 7);
      if (r == 0)      spd = -16384;
      else if (r == 1) spd = 16383;
      else if (r == 2) spd = 0;
      else             spd = $urandom_range(0, 32767);
      if (eon) eon = ($urandom_range(0, 3) != 0);
      else     eon = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 7) == 0, spd, eon);
    end
    step(1'b0, 0, 1'b0);

    for (int i = 0; i < 5 && (exp_q.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size() + dq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
